// File: rtl/alu_if.sv
// Operand/opcode request and result bundle between a requester and the ALU.
// The requester drives the i_* fields, the ALU drives the o_* fields.
interface alu_if #(
    parameter int DATA_W = 12,
    parameter int INST_W = 3
);
    logic              i_valid;
    logic [DATA_W-1:0] i_data_a;
    logic [DATA_W-1:0] i_data_b;
    logic [INST_W-1:0] i_inst;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_overflow;

    modport master (
        output i_valid, i_data_a, i_data_b, i_inst,
        input  o_valid, o_data, o_overflow
    );

    modport slave (
        input  i_valid, i_data_a, i_data_b, i_inst,
        output o_valid, o_data, o_overflow
    );
endinterface

// File: rtl/alu.sv
// Q7.5 fixed-point ALU: add/sub/mul/mac, hard tanh, xnor, clz, rotate-left.
// Latency: 1 cycle, all outputs registered; one result per accepted input.
// Backpressure: none, an operation is accepted on every cycle with i_valid high.
module alu #(
    parameter int INT_W  = 7,
    parameter int FRAC_W = 5,
    parameter int INST_W = 3,
    parameter int DATA_W = INT_W + FRAC_W
) (
    input logic  i_clk,
    input logic  i_rst_n,
    alu_if.slave bus
);
    localparam int MAC_W = 2 * DATA_W + 2;
    localparam int CLZ_W = $clog2(DATA_W + 1);

    localparam logic signed [MAC_W-1:0]  RND     = MAC_W'(2 ** (FRAC_W - 1));
    localparam logic signed [MAC_W-1:0]  MAX_V   = MAC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [MAC_W-1:0]  MIN_V   = -MAX_V - MAC_W'(1);
    localparam logic signed [DATA_W-1:0] ONE     = DATA_W'(2 ** FRAC_W);
    localparam logic signed [DATA_W-1:0] NEG_ONE = -ONE;

    typedef enum logic [INST_W-1:0] {
        OP_ADD   = INST_W'(0),
        OP_SUB   = INST_W'(1),
        OP_MUL   = INST_W'(2),
        OP_MAC   = INST_W'(3),
        OP_HTANH = INST_W'(4),
        OP_XNOR  = INST_W'(5),
        OP_CLZ   = INST_W'(6),
        OP_ROTL  = INST_W'(7)
    } op_e;

    op_e                       op;
    logic signed [DATA_W-1:0]  a;
    logic signed [DATA_W-1:0]  b;
    logic signed [DATA_W-1:0]  acc;
    logic signed [DATA_W:0]    add_sum;
    logic signed [DATA_W:0]    sub_dif;
    logic signed [MAC_W-1:0]   prod;
    logic signed [MAC_W-1:0]   mul_r;
    logic signed [MAC_W-1:0]   mac_r;
    logic [CLZ_W-1:0]          clz;
    logic [3:0]                rot_sh;
    logic [2*DATA_W-1:0]       rot_dbl;
    logic [DATA_W-1:0]         res;
    logic                      ovf;

    assign op      = op_e'(bus.i_inst);
    assign a       = $signed(bus.i_data_a);
    assign b       = $signed(bus.i_data_b);
    assign add_sum = (DATA_W + 1)'(a) + (DATA_W + 1)'(b);
    assign sub_dif = (DATA_W + 1)'(a) - (DATA_W + 1)'(b);
    assign prod    = MAC_W'(a) * MAC_W'(b);
    assign mul_r   = (prod + RND) >>> FRAC_W;
    // Accumulator is aligned to the Q14.10 product before rounding back to Q7.5.
    assign mac_r   = (prod + (MAC_W'(acc) <<< FRAC_W) + RND) >>> FRAC_W;
    assign rot_sh  = bus.i_data_b[3:0] % 4'd12;
    assign rot_dbl = {bus.i_data_a, bus.i_data_a} << rot_sh;

    always_comb begin
        clz = CLZ_W'(DATA_W);
        for (int i = 0; i < DATA_W; i++) begin
            if (bus.i_data_a[i]) clz = CLZ_W'(DATA_W - 1 - i);
        end
    end

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin
                res = add_sum[DATA_W-1:0];
                ovf = add_sum[DATA_W] ^ add_sum[DATA_W-1];
            end
            OP_SUB: begin
                res = sub_dif[DATA_W-1:0];
                ovf = sub_dif[DATA_W] ^ sub_dif[DATA_W-1];
            end
            OP_MUL: begin
                res = mul_r[DATA_W-1:0];
                ovf = (mul_r > MAX_V) || (mul_r < MIN_V);
            end
            OP_MAC: begin
                res = mac_r[DATA_W-1:0];
                ovf = (mac_r > MAX_V) || (mac_r < MIN_V);
            end
            OP_HTANH: begin
                if (a >= ONE)          res = ONE;
                else if (a <= NEG_ONE) res = NEG_ONE;
                else                   res = a;
            end
            OP_XNOR: res = ~(bus.i_data_a ^ bus.i_data_b);
            OP_CLZ:  res = DATA_W'(clz);
            OP_ROTL: res = rot_dbl[2*DATA_W-1 -: DATA_W];
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            bus.o_valid    <= 1'b0;
            bus.o_data     <= '0;
            bus.o_overflow <= 1'b0;
            acc            <= '0;
        end else begin
            bus.o_valid <= bus.i_valid;
            if (bus.i_valid) begin
                bus.o_data     <= ovf ? '0 : res;
                bus.o_overflow <= ovf;
                if (op == OP_MAC) begin
                    if (!ovf) acc <= mac_r[DATA_W-1:0];
                end else begin
                    acc <= '0;
                end
            end else begin
                bus.o_data     <= '0;
                bus.o_overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu.sv
// Directed and randomized checks of the Q7.5 ALU against an integer reference model.
module tb_alu;
    localparam int DATA_W = 12;
    localparam int INST_W = 3;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    alu_if #(.DATA_W(DATA_W), .INST_W(INST_W)) bus ();

    alu dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int m_acc    = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input logic [DATA_W-1:0] v);
        return (v >= 12'h800) ? int'(v) - 4096 : int'(v);
    endfunction

    function automatic bit out_of_range(input int r);
        return (r < -2048) || (r > 2047);
    endfunction

    // Reference: plain integer arithmetic; floor division by 32 is the >>>5.
    function automatic void ref_op(input logic [2:0] op, input logic [DATA_W-1:0] a_raw,
                                   input logic [DATA_W-1:0] b_raw, inout int acc,
                                   output logic [DATA_W-1:0] d, output logic ovf);
        int a, b, r, n, au;
        a   = sx(a_raw);
        b   = sx(b_raw);
        au  = int'(a_raw);
        r   = 0;
        ovf = 1'b0;
        case (op)
            3'd0: begin r = a + b; ovf = out_of_range(r); end
            3'd1: begin r = a - b; ovf = out_of_range(r); end
            3'd2: begin r = (a * b + 16) >>> 5; ovf = out_of_range(r); end
            3'd3: begin r = (a * b + acc * 32 + 16) >>> 5; ovf = out_of_range(r); end
            3'd4: r = (a >= 32) ? 32 : ((a <= -32) ? -32 : a);
            3'd5: r = ~(au ^ int'(b_raw));
            3'd6: begin
                r = 0;
                for (int i = DATA_W - 1; i >= 0 && !a_raw[i]; i--) r++;
            end
            default: begin
                n = int'(b_raw[3:0]) % 12;
                r = ((au << n) | (au >> (12 - n))) & 'hFFF;
            end
        endcase
        if (op == 3'd3) begin
            if (!ovf) acc = r;
        end else begin
            acc = 0;
        end
        d = ovf ? '0 : r[DATA_W-1:0];
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        @(negedge i_clk);
        bus.i_valid  = v;
        bus.i_inst   = op;
        bus.i_data_a = a;
        bus.i_data_b = b;
    endtask

    // Directed step: constants from the requirements are the expectations.
    task automatic dir(input string tag, input logic [2:0] op, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] exp_d, input logic exp_o);
        logic [DATA_W-1:0] md;
        logic mo;
        drive(1'b1, op, a, b);
        ref_op(op, a, b, m_acc, md, mo);
        @(posedge i_clk);
        #1;
        check({tag, ".vld"}, 12'(bus.o_valid), 12'd1);
        check({tag, ".dat"}, bus.o_data, exp_d);
        check({tag, ".ovf"}, 12'(bus.o_overflow), 12'(exp_o));
    endtask

    initial begin
        logic [DATA_W-1:0] q_d[$];
        logic              q_o[$];
        logic [DATA_W-1:0] ed;
        logic              eo;
        logic              v;
        logic [2:0]        op;
        logic [DATA_W-1:0] ra, rb;
        int                sent, pulses;

        bus.i_valid  = 1'b0;
        bus.i_inst   = '0;
        bus.i_data_a = '0;
        bus.i_data_b = '0;

        #2 i_rst_n = 1'b1;
        #1;
        check("rst.vld", 12'(bus.o_valid), 12'd0);
        check("rst.dat", bus.o_data, 12'd0);
        check("rst.ovf", 12'(bus.o_overflow), 12'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        m_acc   = 0;

        dir("add_ovf",  3'd0, 12'h7FF, 12'h001, 12'h000, 1'b1);
        dir("sub",      3'd1, 12'h040, 12'h020, 12'h020, 1'b0);
        dir("add_neg",  3'd0, 12'h800, 12'hFFF, 12'h000, 1'b1);
        dir("mul",      3'd2, 12'h030, 12'h030, 12'h048, 1'b0);
        dir("mul_ovf",  3'd2, 12'h7FF, 12'h7FF, 12'h000, 1'b1);
        dir("mac1",     3'd3, 12'h020, 12'h020, 12'h020, 1'b0);
        dir("mac2",     3'd3, 12'h020, 12'h020, 12'h040, 1'b0);
        dir("add0",     3'd0, 12'h000, 12'h000, 12'h000, 1'b0);
        dir("mac3",     3'd3, 12'h020, 12'h020, 12'h020, 1'b0);
        dir("htanh_hi", 3'd4, 12'h050, 12'h123, 12'h020, 1'b0);
        dir("htanh_lo", 3'd4, 12'hF00, 12'h7FF, 12'hFE0, 1'b0);
        dir("htanh_in", 3'd4, 12'h010, 12'h800, 12'h010, 1'b0);
        dir("clz1",     3'd6, 12'h001, 12'hFFF, 12'd11,  1'b0);
        dir("clz0",     3'd6, 12'h000, 12'h555, 12'd12,  1'b0);
        dir("clz_msb",  3'd6, 12'h800, 12'h000, 12'd0,   1'b0);
        dir("rotl",     3'd7, 12'h801, 12'h001, 12'h003, 1'b0);
        dir("rotl_13",  3'd7, 12'h801, 12'h00D, 12'h003, 1'b0);
        dir("xnor",     3'd5, 12'hF0F, 12'h0FF, 12'h00F, 1'b0);

        // Random opcodes with random gaps; results must come back in order, one cycle later.
        sent   = 0;
        pulses = 0;
        for (int c = 0; c < 400 && !(sent == 20 && q_d.size() == 0); c++) begin
            v  = (sent < 20) && ($urandom_range(0, 2) != 0);
            op = 3'($urandom_range(0, 7));
            ra = 12'($urandom);
            rb = 12'($urandom);
            drive(v, op, ra, rb);
            if (v) begin
                ref_op(op, ra, rb, m_acc, ed, eo);
                q_d.push_back(ed);
                q_o.push_back(eo);
                sent++;
            end
            @(posedge i_clk);
            #1;
            check("rnd.vld", 12'(bus.o_valid), 12'(v));
            if (bus.o_valid) begin
                pulses++;
                if (q_d.size() > 0) begin
                    check("rnd.dat", bus.o_data, q_d.pop_front());
                    check("rnd.ovf", 12'(bus.o_overflow), 12'(q_o.pop_front()));
                end
            end else begin
                check("idle.dat", bus.o_data, 12'd0);
                check("idle.ovf", 12'(bus.o_overflow), 12'd0);
            end
        end
        check("rnd.pulses", 12'(pulses), 12'd20);

        // Load a nonzero accumulator, then reset between edges with a result on the outputs.
        dir("mac_pre", 3'd3, 12'h020, 12'h020, 12'h020, 1'b0);
        drive(1'b1, 3'd3, 12'h020, 12'h020);
        @(posedge i_clk);
        #1;
        check("pre_rst.vld", 12'(bus.o_valid), 12'd1);
        #1 i_rst_n = 1'b1;
        #1;
        check("mid_rst.vld", 12'(bus.o_valid), 12'd0);
        check("mid_rst.dat", bus.o_data, 12'd0);
        @(posedge i_clk);
        #1;
        check("hold_rst.vld", 12'(bus.o_valid), 12'd0);
        @(negedge i_clk);
        i_rst_n     = 1'b0;
        bus.i_valid = 1'b0;
        m_acc       = 0;
        dir("post_rst_mac", 3'd3, 12'h020, 12'h020, 12'h020, 1'b0);
        drive(1'b0, 3'd0, 12'h000, 12'h000);
        @(posedge i_clk);
        #1;
        check("tail.vld", 12'(bus.o_valid), 12'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have parameters INT_W = 7 (integer bits), FRAC_W = 5 (fraction bits), INST_W = 3 (opcode width), DATA_W = INT_W+FRAC_W = 12; all data is signed two's-complement fixed point Q7.5.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 i_clk  input  1  clock; all state updates on the rising edge.
REQ-004 i_rst_n  input  1  asynchronous reset; asserted when 1, despite the _n suffix.
REQ-005 i_valid  input  1  operands and opcode valid this cycle.
REQ-006 i_data_a  input  DATA_W  signed operand A.
REQ-007 i_data_b  input  DATA_W  signed operand B.
REQ-008 i_inst  input  INST_W  opcode.
REQ-009 o_valid  output  1  result valid; high for exactly one cycle per accepted input.
REQ-010 o_data  output  DATA_W  signed result.
REQ-011 o_overflow  output  1  result not representable in Q7.5.

Function
REQ-012 SHALL accept an operation on every rising edge where i_valid=1; there is no backpressure, and back-to-back inputs are legal.
REQ-013 SHALL register all outputs; o_valid, o_data and o_overflow SHALL be valid on the edge after acceptance (latency 1 cycle).
REQ-014 On a cycle with no accepted input, o_valid SHALL be 0 on the next cycle, and o_data/o_overflow SHALL be driven to 0.
REQ-015 When o_overflow=1, o_data SHALL be 0.
REQ-016 Opcode 000 ADD: a+b, computed in 13 bits; overflow if the result lies outside [-2048, 2047].
REQ-017 Opcode 001 SUB: a-b; overflow rule as for ADD.
REQ-018 Opcode 010 MUL: p=a*b (24-bit, Q14.10); r=(p+16)>>>5 (round half up); overflow if r lies outside the 12-bit signed range; otherwise o_data=r[11:0].
REQ-019 Opcode 011 MAC: r=(a*b + (acc<<<5) + 16)>>>5, computed at full width; overflow rule as for MUL.
REQ-020 MAC accumulator: acc is an internal 12-bit register; on MAC without overflow, acc<=r; on MAC with overflow, acc is unchanged.
REQ-021 Any accepted non-MAC opcode SHALL clear acc to 0.
REQ-022 Opcode 100 HTANH: a>=0x020 (+1.0) -> 0x020; a<=0xFE0 (-1.0) -> 0xFE0; else -> a; never overflows.
REQ-023 Opcode 101 XNOR: ~(a^b) bitwise; never overflows.
REQ-024 Opcode 110 CLZ: number of leading zeros of a as an unsigned integer (not fixed point), range 0..12; a=0 -> 12; never overflows.
REQ-025 Opcode 111 ROTL: a rotated left by (b[3:0] mod 12) bit positions; never overflows.
REQ-026 Operand B SHALL be ignored by HTANH and CLZ.

Reset
REQ-027 While i_rst_n=1, o_valid, o_data, o_overflow and acc SHALL be 0 immediately (asynchronous), with no clock required.
REQ-028 Reset asserted mid-stream SHALL discard any pending result; no o_valid is produced for inputs accepted before reset.
REQ-029 After reset deasserts, the first i_valid=1 sampled SHALL produce o_valid on the following edge.

Verification
REQ-030 ADD: a=0x7FF, b=0x001 -> o_overflow=1, o_data=0; SUB: a=0x040, b=0x020 -> o_data=0x020, o_overflow=0.
REQ-031 MUL: a=0x030, b=0x030 (1.5*1.5) -> 0x048; MUL: a=0x7FF, b=0x7FF -> o_overflow=1.
REQ-032 MAC twice back-to-back with a=b=0x020 -> 0x020, then 0x040; then ADD 0 to 0, then MAC a=b=0x020 -> 0x020 (acc was cleared).
REQ-033 HTANH: a=0x050 -> 0x020; a=0xF00 -> 0xFE0; a=0x010 -> 0x010. CLZ: a=0x001 -> 11; a=0x000 -> 12; a=0x800 -> 0.
REQ-034 ROTL: a=0x801, b=0x001 -> 0x003. XNOR: a=0xF0F, b=0x0FF -> 0x00F.
REQ-035 Random i_valid gaps with 20 queued operations -> exactly 20 o_valid pulses, in order, each one cycle after its input; reset pulse mid-stream -> outputs 0 immediately.
